// File: rtl/btb_pkg.sv
// btb_pkg: shared types and constants for the BTB update path.
//   BTB_ROWS / INDEX_W / TAG_W : default BTB geometry (index taken from pc[5:2])
//   btb_update_t               : one resolved-branch update as buffered in the FIFO
//   btb_state_t                : update-controller FSM states
package btb_pkg;

  localparam int DATA_W   = 32;
  localparam int BTB_ROWS = 16;
  localparam int INDEX_W  = $clog2(BTB_ROWS);
  localparam int TAG_W    = DATA_W - 6;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] target;
    logic              taken;
    logic              uncond;
  } btb_update_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } btb_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous active-low reset and a
// synchronous flush that empties it in one cycle.
//   clk, rst     : clock, synchronous active-low reset
//   flush        : discard all contents (wins over push/pop)
//   push, din    : write din when push (caller guarantees !full)
//   pop, dout    : dout is the head entry; pop advances (caller guarantees !empty)
//   empty, full  : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count_r == '0);
  assign full  = (count_r == CNT_W'(DEPTH));
  assign dout  = mem_r[rd_ptr_r];

  // Storage array: data only, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= ptr_next(wr_ptr_r);
      if (pop)  rd_ptr_r <= ptr_next(rd_ptr_r);
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/btb_update_controller.sv
// btb_update_controller: buffers resolved branch/JAL updates and writes them
// into the BTB through a port shared with lookup; also sweeps the whole BTB
// invalid on flush_req.
//   clk, rst                 : clock, synchronous active-low reset
//   res_valid/res_ready      : update handshake from execute
//   res_pc/target/taken/uncond : update payload
//   flush_req                : invalidate the whole BTB (discards pending updates)
//   btb_port_busy            : lookup owns the BTB port this cycle, no write
//   wr_en, wr_index, wr_valid, wr_pred, wr_uncond, wr_tag, wr_target : registered BTB write
//   busy                     : sweep in progress or updates pending
module btb_update_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int BTB_ROWS   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          res_valid,
  output logic                          res_ready,
  input  logic [DATA_WIDTH-1:0]         res_pc,
  input  logic [DATA_WIDTH-1:0]         res_target,
  input  logic                          res_taken,
  input  logic                          res_uncond,
  input  logic                          flush_req,
  input  logic                          btb_port_busy,
  output logic                          wr_en,
  output logic [$clog2(BTB_ROWS)-1:0]   wr_index,
  output logic                          wr_valid,
  output logic                          wr_pred,
  output logic                          wr_uncond,
  output logic [DATA_WIDTH-7:0]         wr_tag,
  output logic [DATA_WIDTH-1:0]         wr_target,
  output logic                          busy
);

  import btb_pkg::*;

  localparam int IDX_W = $clog2(BTB_ROWS);

  btb_state_t  state_r, state_next_s;
  logic [IDX_W-1:0] sweep_r;
  btb_update_t upd_in_s, upd_head_s;
  logic fifo_empty_s, fifo_full_s;
  logic push_s, pop_s, fifo_flush_s, sweep_wr_s, sweep_last_s;
  logic unused_pc_s;

  assign upd_in_s.pc     = res_pc;
  assign upd_in_s.target = res_target;
  assign upd_in_s.taken  = res_taken;
  assign upd_in_s.uncond = res_uncond;

  // No pass-through: a full FIFO refuses even if it pops this cycle.
  assign res_ready    = rst && (state_r == ST_IDLE) && !flush_req && !fifo_full_s;
  assign push_s       = res_valid && res_ready;
  assign pop_s        = rst && (state_r == ST_IDLE) && !fifo_empty_s
                        && !btb_port_busy && !flush_req;
  assign fifo_flush_s = (state_r == ST_IDLE) && flush_req;
  assign sweep_wr_s   = (state_r == ST_FLUSH) && !btb_port_busy;
  assign sweep_last_s = (sweep_r == IDX_W'(BTB_ROWS - 1));
  assign busy         = (state_r == ST_FLUSH) || !fifo_empty_s;
  assign unused_pc_s  = ^upd_head_s.pc[1:0];

  sync_fifo #(
    .WIDTH ($bits(btb_update_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (upd_in_s),
    .dout  (upd_head_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; flush_req is only honoured from IDLE, so a sweep never restarts.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (flush_req) state_next_s = ST_FLUSH;
        else           state_next_s = ST_IDLE;
      end
      ST_FLUSH: begin
        if (sweep_wr_s && sweep_last_s) state_next_s = ST_IDLE;
        else                            state_next_s = ST_FLUSH;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Sweep index: cleared on flush entry, advances only on cycles that write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sweep_r <= '0;
    end else if (fifo_flush_s) begin
      sweep_r <= '0;
    end else if (sweep_wr_s) begin
      sweep_r <= sweep_last_s ? '0 : sweep_r + IDX_W'(1);
    end
  end

  // Registered BTB write port; fields are zeroed on cycles without a write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en     <= 1'b0;
      wr_index  <= '0;
      wr_valid  <= 1'b0;
      wr_pred   <= 1'b0;
      wr_uncond <= 1'b0;
      wr_tag    <= '0;
      wr_target <= '0;
    end else if (pop_s) begin
      wr_en     <= 1'b1;
      wr_index  <= upd_head_s.pc[IDX_W+1:2];
      wr_valid  <= 1'b1;
      wr_pred   <= upd_head_s.taken;
      wr_uncond <= upd_head_s.uncond;
      wr_tag    <= upd_head_s.pc[DATA_WIDTH-1:6];
      wr_target <= upd_head_s.target;
    end else if (sweep_wr_s) begin
      wr_en     <= 1'b1;
      wr_index  <= sweep_r;
      wr_valid  <= 1'b0;
      wr_pred   <= 1'b0;
      wr_uncond <= 1'b0;
      wr_tag    <= '0;
      wr_target <= '0;
    end else begin
      wr_en     <= 1'b0;
      wr_index  <= '0;
      wr_valid  <= 1'b0;
      wr_pred   <= 1'b0;
      wr_uncond <= 1'b0;
      wr_tag    <= '0;
      wr_target <= '0;
    end
  end

endmodule

// File: tb/tb_btb_update_controller.sv
// Directed self-checking bench for btb_update_controller (default parameters).
module tb_btb_update_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic        res_taken;
  logic        res_uncond;
  logic        flush_req;
  logic        btb_port_busy;
  logic        wr_en;
  logic [3:0]  wr_index;
  logic        wr_valid;
  logic        wr_pred;
  logic        wr_uncond;
  logic [25:0] wr_tag;
  logic [31:0] wr_target;
  logic        busy;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  btb_update_controller dut (
    .clk           (clk),
    .rst           (rst),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_pc        (res_pc),
    .res_target    (res_target),
    .res_taken     (res_taken),
    .res_uncond    (res_uncond),
    .flush_req     (flush_req),
    .btb_port_busy (btb_port_busy),
    .wr_en         (wr_en),
    .wr_index      (wr_index),
    .wr_valid      (wr_valid),
    .wr_pred       (wr_pred),
    .wr_uncond     (wr_uncond),
    .wr_tag        (wr_tag),
    .wr_target     (wr_target),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_write(input string tag);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
  endtask

  initial begin
    rst = 1'b0; res_valid = 1'b0; res_pc = '0; res_target = '0;
    res_taken = 1'b0; res_uncond = 1'b0; flush_req = 1'b0; btb_port_busy = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_ready", 64'(res_ready), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_busy",  64'(busy), 64'(0));
    rst = 1'b1; #1;
    chk("post_rst_ready", 64'(res_ready), 64'(1));

    // Single update: pc 0x48 -> index 2, tag 1
    res_valid = 1'b1; res_pc = 32'h0000_0048; res_target = 32'h0000_0100; res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    chk_idle_write("single_lat1");
    chk("single_busy", 64'(busy), 64'(1));
    tick();
    chk("single_wr_en",  64'(wr_en), 64'(1));
    chk("single_index",  64'(wr_index), 64'(2));
    chk("single_tag",    64'(wr_tag), 64'(1));
    chk("single_target", 64'(wr_target), 64'(32'h100));
    chk("single_pred",   64'(wr_pred), 64'(1));
    chk("single_valid",  64'(wr_valid), 64'(1));
    chk("single_uncond", 64'(wr_uncond), 64'(0));
    tick();
    chk_idle_write("single_after");
    chk("single_busy_done", 64'(busy), 64'(0));

    // Five back-to-back offers with port busy: four fit
    btb_port_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      res_valid = 1'b1; res_pc = 32'h0000_1000 + 32'(i * 4);
      res_target = 32'h0000_2000 + 32'(i); res_taken = (i % 2 == 1); res_uncond = (i == 3);
      #1;
      chk($sformatf("fill_ready_%0d", i), 64'(res_ready), 64'((i < 4) ? 1 : 0));
      tick();
    end
    res_valid = 1'b0;
    chk_idle_write("fill_held");
    btb_port_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drain_en_%0d", i),     64'(wr_en), 64'(1));
      chk($sformatf("drain_idx_%0d", i),    64'(wr_index), 64'(i));
      chk($sformatf("drain_tgt_%0d", i),    64'(wr_target), 64'(32'h2000 + i));
      chk($sformatf("drain_tag_%0d", i),    64'(wr_tag), 64'(26'h40));
      chk($sformatf("drain_pred_%0d", i),   64'(wr_pred), 64'(i % 2));
      chk($sformatf("drain_uncond_%0d", i), 64'(wr_uncond), 64'((i == 3) ? 1 : 0));
    end
    tick();
    chk_idle_write("drain_done");
    chk("drain_busy", 64'(busy), 64'(0));

    // Three pending, then flush_req together with a new offer
    btb_port_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1; res_pc = 32'h0000_3000 + 32'(i * 4); res_target = 32'h4000;
      res_taken = 1'b1; res_uncond = 1'b0;
      tick();
    end
    res_pc = 32'h0000_5000;
    flush_req = 1'b1; btb_port_busy = 1'b0; #1;
    chk("flush_vs_valid_ready", 64'(res_ready), 64'(0));
    tick();
    flush_req = 1'b0; res_valid = 1'b0;
    chk_idle_write("flush_entry");
    chk("flush_busy", 64'(busy), 64'(1));
    for (int k = 0; k < 16; k++) begin
      flush_req = (k == 5);
      tick();
      chk($sformatf("sweep_en_%0d", k),    64'(wr_en), 64'(1));
      chk($sformatf("sweep_idx_%0d", k),   64'(wr_index), 64'(k));
      chk($sformatf("sweep_valid_%0d", k), 64'(wr_valid), 64'(0));
      chk($sformatf("sweep_pred_%0d", k),  64'(wr_pred), 64'(0));
    end
    flush_req = 1'b0;
    chk("sweep_busy_end", 64'(busy), 64'(0));
    tick();
    chk_idle_write("sweep_no_stale");
    chk("sweep_idle_busy", 64'(busy), 64'(0));

    // Sweep with port busy every other cycle: 16 writes over 31 cycles
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    begin
      int exp_idx = 0;
      int cyc = 0;
      while (exp_idx < 16 && cyc < 40) begin
        btb_port_busy = cyc[0];
        tick();
        if (btb_port_busy) begin
          chk($sformatf("pulse_hold_%0d", cyc), 64'(wr_en), 64'(0));
        end else begin
          chk($sformatf("pulse_en_%0d", cyc),  64'(wr_en), 64'(1));
          chk($sformatf("pulse_idx_%0d", cyc), 64'(wr_index), 64'(exp_idx));
          exp_idx++;
        end
        cyc++;
      end
      chk("pulse_cycles", 64'(cyc), 64'(31));
    end
    btb_port_busy = 1'b0;
    chk("pulse_busy_end", 64'(busy), 64'(0));

    // Reset in the middle of a sweep at index 7
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("mid_idx6", 64'(wr_index), 64'(6));
    rst = 1'b0;
    tick();
    chk("mrst_wr_en",  64'(wr_en), 64'(0));
    chk("mrst_index",  64'(wr_index), 64'(0));
    chk("mrst_target", 64'(wr_target), 64'(0));
    chk("mrst_busy",   64'(busy), 64'(0));
    chk("mrst_ready",  64'(res_ready), 64'(0));
    rst = 1'b1; #1;
    chk("mrst_ready_after", 64'(res_ready), 64'(1));
    tick();
    chk_idle_write("mrst_no_write");
    chk("mrst_busy_after", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
